msrh_l2_line_responder: RTL and testbench

L2-side responder terminating the L1D refill request channel. Accepts line-sized requests on `l2_req_if.slave` and queues them in order. After a fixed latency, returns one response per request on `l2_resp_if.master`, echoing the request tag. Line data comes from an internal backing array. Serves as the L2/memory model behind the L1D load requester in core-level simulation and as the template for the real L2 front end.

---
 rtl/msrh_l2_line_responder.sv | 194 +++++++++++++++++++
 tb/tb_msrh_l2_line_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_l2_line_responder.sv
// rtl/msrh_l2_line_responder.sv - L2-side line responder with in-order request queue and fixed latency
//
// Purpose:
//   Terminates the L1D refill request channel. Requests are queued in order,
//   serviced one at a time from an internal line array, and answered with one
//   response per request after a fixed latency, echoing the request tag.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   l2_req_valid/ready        request handshake (accept on valid & ready)
//   l2_req_payload_cmd        M_XWR writes, anything else reads
//   l2_req_payload_addr       line address, low byte-offset bits ignored
//   l2_req_payload_tag        returned unmodified in the response
//   l2_req_payload_data       write line data
//   l2_req_payload_byte_en    write byte enables
//   l2_resp_valid/ready       response handshake
//   l2_resp_payload_tag       tag of the serviced request
//   l2_resp_payload_data      read line, zero for writes
//
// Configuration:
//   MSRH_L2_RESP_BACKPRESSURE_EN  when defined, RESP holds until l2_resp_ready;
//                                 otherwise l2_resp_valid is a one-cycle pulse
//                                 and l2_resp_ready is ignored.

module msrh_l2_line_responder #(
  parameter int REQ_Q_DEPTH     = 4,
  parameter int LATENCY         = 4,
  parameter int MEM_LINES       = 1024,
  parameter int PADDR_W         = 32,
  parameter int L2_CMD_TAG_W    = 8,
  parameter int DCACHE_DATA_W   = 128,
  parameter int DCACHE_DATA_B_W = DCACHE_DATA_W / 8,
  parameter int CMD_W           = 5,
  parameter logic [CMD_W-1:0] M_XWR = 5'b00001
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       l2_req_valid,
  output logic                       l2_req_ready,
  input  logic [CMD_W-1:0]           l2_req_payload_cmd,
  input  logic [PADDR_W-1:0]         l2_req_payload_addr,
  input  logic [L2_CMD_TAG_W-1:0]    l2_req_payload_tag,
  input  logic [DCACHE_DATA_W-1:0]   l2_req_payload_data,
  input  logic [DCACHE_DATA_B_W-1:0] l2_req_payload_byte_en,
  output logic                       l2_resp_valid,
  input  logic                       l2_resp_ready,
  output logic [L2_CMD_TAG_W-1:0]    l2_resp_payload_tag,
  output logic [DCACHE_DATA_W-1:0]   l2_resp_payload_data
);

  localparam int PTR_W     = $clog2(REQ_Q_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int LINE_LSB  = $clog2(DCACHE_DATA_B_W);
  localparam int IDX_W     = $clog2(MEM_LINES);
  localparam int LAT_CNT_W = $clog2(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Request queue: the command is reduced to a write flag and the address to
  // its line index at push time, since nothing else of them is ever consulted.
  logic                       q_wr   [REQ_Q_DEPTH];
  logic [IDX_W-1:0]           q_idx  [REQ_Q_DEPTH];
  logic [L2_CMD_TAG_W-1:0]    q_tag  [REQ_Q_DEPTH];
  logic [DCACHE_DATA_W-1:0]   q_data [REQ_Q_DEPTH];
  logic [DCACHE_DATA_B_W-1:0] q_be   [REQ_Q_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] q_count;

  logic [DCACHE_DATA_W-1:0] mem [MEM_LINES];

  state_t                    state;
  logic [LAT_CNT_W-1:0]      cnt;
  logic                      wk_wr;
  logic [IDX_W-1:0]          wk_idx;
  logic [L2_CMD_TAG_W-1:0]   wk_tag;
  logic                      resp_valid_q;
  logic [L2_CMD_TAG_W-1:0]   resp_tag_q;
  logic [DCACHE_DATA_W-1:0]  resp_data_q;

  logic push;
  logic pop;
  logic unused_addr;

  // Only the line-index slice of the address matters; the rest is folded
  // into a dummy so every address bit is consumed.
  assign unused_addr = ^l2_req_payload_addr;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never lets a push through on a full queue. Held low throughout reset.
  assign l2_req_ready = ~i_reset & (q_count != CNT_W'(REQ_Q_DEPTH));
  assign push         = l2_req_valid & l2_req_ready;
  assign pop          = (state == S_IDLE) && (q_count != '0);

  // Queue pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read below the count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_wr[wr_ptr]   <= (l2_req_payload_cmd == M_XWR);
      q_idx[wr_ptr]  <= l2_req_payload_addr[LINE_LSB +: IDX_W];
      q_tag[wr_ptr]  <= l2_req_payload_tag;
      q_data[wr_ptr] <= l2_req_payload_data;
      q_be[wr_ptr]   <= l2_req_payload_byte_en;
    end
  end

  // Writes land in the array at pop, so any later request in the queue sees
  // them regardless of how soon it follows.
  always_ff @(posedge i_clk) begin
    if (!i_reset && pop && q_wr[rd_ptr]) begin
      for (int b = 0; b < DCACHE_DATA_B_W; b++) begin
        if (q_be[rd_ptr][b]) begin
          mem[q_idx[rd_ptr]][b*8 +: 8] <= q_data[rd_ptr][b*8 +: 8];
        end
      end
    end
  end

  // Service FSM: IDLE pops, WAIT burns the latency, RESP presents the
  // registered response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wk_wr        <= 1'b0;
      wk_idx       <= '0;
      wk_tag       <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            wk_wr  <= q_wr[rd_ptr];
            wk_idx <= q_idx[rd_ptr];
            wk_tag <= q_tag[rd_ptr];
            cnt    <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAT_CNT_W'(LATENCY - 3)) begin
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_tag_q   <= wk_tag;
            resp_data_q  <= wk_wr ? '0 : mem[wk_idx];
          end
        end
        S_RESP: begin
`ifdef MSRH_L2_RESP_BACKPRESSURE_EN
          if (l2_resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= S_IDLE;
          end
`else
          resp_valid_q <= 1'b0;
          state        <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef MSRH_L2_RESP_BACKPRESSURE_EN
  // The current L1D receiver has no ready; the input exists for port parity.
  logic unused_resp_ready;
  assign unused_resp_ready = l2_resp_ready;
`endif

  assign l2_resp_valid        = resp_valid_q;
  assign l2_resp_payload_tag  = resp_tag_q;
  assign l2_resp_payload_data = resp_data_q;

endmodule

// File: tb/tb_msrh_l2_line_responder.sv
// tb/tb_msrh_l2_line_responder.sv - directed self-checking bench for msrh_l2_line_responder

module tb_msrh_l2_line_responder;

  localparam int TAG_W  = 8;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;
  localparam int CMD_W  = 5;
  localparam int ADDR_W = 32;
  localparam int LAT    = 4;

  localparam logic [CMD_W-1:0] M_XRD = 5'b00000;
  localparam logic [CMD_W-1:0] M_XWR = 5'b00001;

  localparam logic [DATA_W-1:0] LINE_A5  = {16{8'hA5}};
  localparam logic [DATA_W-1:0] LINE_PAT = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DATA_W-1:0] LINE_MIX = 128'h00112233_44556677_8899AABB_11223344;

  logic              clk = 1'b0;
  logic              rst;
  logic              l2_req_valid;
  logic              l2_req_ready;
  logic [CMD_W-1:0]  l2_req_cmd;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [TAG_W-1:0]  l2_req_tag;
  logic [DATA_W-1:0] l2_req_data;
  logic [BE_W-1:0]   l2_req_be;
  logic              l2_resp_valid;
  logic              l2_resp_ready;
  logic [TAG_W-1:0]  l2_resp_tag;
  logic [DATA_W-1:0] l2_resp_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [TAG_W-1:0]  rtag_q  [$];
  logic [DATA_W-1:0] rdata_q [$];
  int                rcyc_q  [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  msrh_l2_line_responder #(
    .REQ_Q_DEPTH(4),
    .LATENCY(LAT),
    .MEM_LINES(1024)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .l2_req_valid           (l2_req_valid),
    .l2_req_ready           (l2_req_ready),
    .l2_req_payload_cmd     (l2_req_cmd),
    .l2_req_payload_addr    (l2_req_addr),
    .l2_req_payload_tag     (l2_req_tag),
    .l2_req_payload_data    (l2_req_data),
    .l2_req_payload_byte_en (l2_req_be),
    .l2_resp_valid          (l2_resp_valid),
    .l2_resp_ready          (l2_resp_ready),
    .l2_resp_payload_tag    (l2_resp_tag),
    .l2_resp_payload_data   (l2_resp_data)
  );

  // Response log, sampled mid-cycle.
  always @(negedge clk) begin
`ifdef MSRH_L2_RESP_BACKPRESSURE_EN
    if (!rst && l2_resp_valid && l2_resp_ready) begin
`else
    if (!rst && l2_resp_valid) begin
`endif
      rtag_q.push_back(l2_resp_tag);
      rdata_q.push_back(l2_resp_data);
      rcyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents one request and returns one cycle after it is accepted; valid is
  // left high so consecutive calls stream back-to-back.
  task automatic drive(input logic [CMD_W-1:0] c, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be, output int acc);
    acc          = -1;
    l2_req_valid = 1'b1;
    l2_req_cmd   = c;
    l2_req_addr  = a;
    l2_req_tag   = t;
    l2_req_data  = d;
    l2_req_be    = be;
    for (int k = 0; k < 64 && acc < 0; k++) begin
      @(negedge clk);
      if (l2_req_ready) acc = cyc;
      @(posedge clk);
      #1;
    end
    check("accept", DATA_W'(acc >= 0), DATA_W'(1));
  endtask

  task automatic wait_resps(input int n, input int budget);
    for (int k = 0; k < budget && rtag_q.size() < n; k++) @(negedge clk);
    @(posedge clk);
    #1;
    check("resp_count", DATA_W'(rtag_q.size()), DATA_W'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rtag_q.delete();
    rdata_q.delete();
    rcyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc_first;
    int offs [6];
    int exp_offs [6];
    int n_stable;

    exp_offs = '{0, 1, 2, 3, 4, 6};

    // Reset with a request pending: nothing accepted, nothing answered.
    rst           = 1'b1;
    l2_resp_ready = 1'b1;
    l2_req_valid  = 1'b1;
    l2_req_cmd    = M_XRD;
    l2_req_addr   = 32'h0000_0000;
    l2_req_tag    = 8'h77;
    l2_req_data   = '0;
    l2_req_be     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", DATA_W'(l2_req_ready), DATA_W'(0));
    check("valid_in_reset", DATA_W'(l2_resp_valid), DATA_W'(0));
    @(posedge clk);
    #1;
    l2_req_valid = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    check("ready_after_reset", DATA_W'(l2_req_ready), DATA_W'(1));
    check("valid_after_reset", DATA_W'(l2_resp_valid), DATA_W'(0));
    check("tag_after_reset", DATA_W'(l2_resp_tag), DATA_W'(0));
    check("data_after_reset", l2_resp_data, '0);
    idle(10);
    check("no_resp_from_reset", DATA_W'(rtag_q.size()), DATA_W'(0));

    // Preload two lines through full-line writes.
    drive(M_XWR, 32'h8000_0040, 8'h01, LINE_A5, 16'hFFFF, acc);
    drive(M_XWR, 32'h0000_0100, 8'h02, LINE_PAT, 16'hFFFF, acc);
    l2_req_valid = 1'b0;
    wait_resps(2, 40);
    check("wr1_tag", DATA_W'(rtag_q[0]), DATA_W'(8'h01));
    check("wr1_data_zero", rdata_q[0], '0);
    check("wr2_tag", DATA_W'(rtag_q[1]), DATA_W'(8'h02));
    check("wr2_data_zero", rdata_q[1], '0);
    idle(4);
    clear_log();

    // Unloaded read: response valid LAT cycles after accept.
    drive(M_XRD, 32'h8000_0040, 8'h05, '0, '0, acc);
    l2_req_valid = 1'b0;
    wait_resps(1, 20);
    check("rd_tag", DATA_W'(rtag_q[0]), DATA_W'(8'h05));
    check("rd_data", rdata_q[0], LINE_A5);
    check("rd_latency", DATA_W'(rcyc_q[0] - acc), DATA_W'(LAT));
    idle(4);
    clear_log();

    // Partial write then read of the same line.
    drive(M_XWR, 32'h0000_0100, 8'h06, 128'h1122_3344, 16'h000F, acc);
    drive(M_XRD, 32'h0000_0100, 8'h07, '0, '0, acc);
    l2_req_valid = 1'b0;
    wait_resps(2, 40);
    check("pw_tag", DATA_W'(rtag_q[0]), DATA_W'(8'h06));
    check("pw_data_zero", rdata_q[0], '0);
    check("raw_tag", DATA_W'(rtag_q[1]), DATA_W'(8'h07));
    check("raw_data", rdata_q[1], LINE_MIX);
    idle(4);
    clear_log();

    // Streamed reads: the queue fills after the fifth push, so the sixth
    // waits one cycle for the next pop.
    acc_first = 0;
    for (int i = 0; i < 6; i++) begin
      drive(M_XRD, 32'h8000_0040, TAG_W'(8'h10 + i), '0, '0, acc);
      if (i == 0) acc_first = acc;
      offs[i] = acc - acc_first;
    end
    l2_req_valid = 1'b0;
    for (int i = 1; i < 6; i++) check($sformatf("accept_offset_%0d", i), DATA_W'(offs[i]), DATA_W'(exp_offs[i]));
    wait_resps(6, 100);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("order_tag_%0d", i), DATA_W'(rtag_q[i]), DATA_W'(8'h10 + i));
      check($sformatf("order_data_%0d", i), rdata_q[i], LINE_A5);
    end
    idle(4);
    clear_log();

`ifdef MSRH_L2_RESP_BACKPRESSURE_EN
    // Response held under back-pressure, then drained in order.
    l2_resp_ready = 1'b0;
    drive(M_XRD, 32'h8000_0040, 8'h20, '0, '0, acc);
    drive(M_XRD, 32'h0000_0100, 8'h21, '0, '0, acc);
    l2_req_valid = 1'b0;
    for (int k = 0; k < 32 && !l2_resp_valid; k++) begin
      @(posedge clk);
      #1;
    end
    n_stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (l2_resp_valid && l2_resp_tag == 8'h20 && l2_resp_data == LINE_A5) n_stable++;
      @(posedge clk);
      #1;
    end
    check("bp_stable_cycles", DATA_W'(n_stable), DATA_W'(10));
    l2_resp_ready = 1'b1;
    wait_resps(2, 40);
    check("bp_tag0", DATA_W'(rtag_q[0]), DATA_W'(8'h20));
    check("bp_tag1", DATA_W'(rtag_q[1]), DATA_W'(8'h21));
    check("bp_data1", rdata_q[1], LINE_MIX);
    idle(4);
    clear_log();
`endif

    // Reset while one request is in WAIT and two are queued.
    drive(M_XRD, 32'h8000_0040, 8'h30, '0, '0, acc);
    drive(M_XRD, 32'h8000_0040, 8'h31, '0, '0, acc);
    drive(M_XRD, 32'h8000_0040, 8'h32, '0, '0, acc);
    l2_req_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", DATA_W'(l2_req_ready), DATA_W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_high", DATA_W'(l2_req_ready), DATA_W'(1));
    check("midrst_valid", DATA_W'(l2_resp_valid), DATA_W'(0));
    check("midrst_tag", DATA_W'(l2_resp_tag), DATA_W'(0));
    check("midrst_data", l2_resp_data, '0);
    idle(20);
    check("midrst_no_resp", DATA_W'(rtag_q.size()), DATA_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
